// File: rtl/servo_pos_ctrl.sv
// Servo position sequencer: angle index, frame-aligned commits, registered PWM.
// Optional SERVO_WRAP_EN: manual up/down wrap around instead of saturating.
module servo_pos_ctrl #(
  parameter int PERIOD_CYC  = 2000000,
  parameter int BASE_CYC    = 50000,
  parameter int STEP_CYC    = 20000,
  parameter int MAX_IDX     = 9,
  parameter int HOLD_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       sweep_en,
  output logic [3:0] st,
  output logic       st_chg,
  output logic       pwm
);

  typedef enum logic [1:0] {MANUAL, SWEEP_UP, SWEEP_DN} state_t;

  localparam logic [3:0]  MAX4       = 4'(MAX_IDX);
  localparam logic [31:0] LAST_CNT   = 32'(PERIOD_CYC - 1);
  localparam logic [31:0] LAST_DWELL = 32'(HOLD_FRAMES - 1);
  localparam logic [31:0] BASE32     = 32'(BASE_CYC);
  localparam logic [31:0] STEP32     = 32'(STEP_CYC);

  state_t      r_state, w_state_nx;
  logic [31:0] r_cnt;
  logic [31:0] r_width;
  logic [3:0]  r_idx, w_idx_nx;
  logic        r_chg;
  logic        r_pwm;
  logic        r_pend_up, r_pend_dn;
  logic        w_pend_up_nx, w_pend_dn_nx;
  logic [31:0] r_dwell, w_dwell_nx;

  logic        w_bnd;
  logic        w_up_req, w_dn_req;
  logic        w_pend_up, w_pend_dn;
  logic [3:0]  w_inc, w_dec;

  assign w_bnd = (r_cnt == LAST_CNT);

  always_comb begin
    // Pending flags as they stand including this cycle's request, so a
    // request on the boundary cycle itself is committed at that boundary.
    w_up_req  = btn_up & ~btn_dn;
    w_dn_req  = btn_dn & ~btn_up;
    w_pend_up = w_up_req | (r_pend_up & ~w_dn_req);
    w_pend_dn = w_dn_req | (r_pend_dn & ~w_up_req);

`ifdef SERVO_WRAP_EN
    w_inc = (r_idx >= MAX4) ? '0   : r_idx + 4'd1;
    w_dec = (r_idx == '0)   ? MAX4 : r_idx - 4'd1;
`else
    w_inc = (r_idx >= MAX4) ? MAX4 : r_idx + 4'd1;
    w_dec = (r_idx == '0)   ? '0   : r_idx - 4'd1;
`endif

    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_pend_up_nx = r_pend_up;
    w_pend_dn_nx = r_pend_dn;
    w_dwell_nx   = r_dwell;

    case (r_state)
      MANUAL: begin
        if (w_bnd) begin
          w_pend_up_nx = 1'b0;
          w_pend_dn_nx = 1'b0;
          if (sweep_en) begin
            w_state_nx = (r_idx < MAX4) ? SWEEP_UP : SWEEP_DN;
            w_dwell_nx = '0;
          end else if (w_pend_up) begin
            w_idx_nx = w_inc;
          end else if (w_pend_dn) begin
            w_idx_nx = w_dec;
          end
        end else begin
          w_pend_up_nx = w_pend_up;
          w_pend_dn_nx = w_pend_dn;
        end
      end
      SWEEP_UP: begin
        if (w_bnd) begin
          if (!sweep_en) begin
            w_state_nx = MANUAL;
            w_dwell_nx = '0;
          end else if (r_dwell >= LAST_DWELL) begin
            w_dwell_nx = '0;
            w_idx_nx   = r_idx + 4'd1;
            if (r_idx + 4'd1 >= MAX4) w_state_nx = SWEEP_DN;
          end else begin
            w_dwell_nx = r_dwell + 32'd1;
          end
        end
      end
      SWEEP_DN: begin
        if (w_bnd) begin
          if (!sweep_en) begin
            w_state_nx = MANUAL;
            w_dwell_nx = '0;
          end else if (r_dwell >= LAST_DWELL) begin
            w_dwell_nx = '0;
            w_idx_nx   = r_idx - 4'd1;
            if (r_idx == 4'd1) w_state_nx = SWEEP_UP;
          end else begin
            w_dwell_nx = r_dwell + 32'd1;
          end
        end
      end
      default: w_state_nx = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= MANUAL;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_width   <= BASE32;
      r_idx     <= '0;
      r_chg     <= 1'b0;
      r_pwm     <= 1'b0;
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
      r_dwell   <= '0;
    end else begin
      r_cnt     <= w_bnd ? '0 : r_cnt + 32'd1;
      r_pwm     <= (r_cnt < r_width);
      r_chg     <= w_bnd && (w_idx_nx != r_idx);
      r_idx     <= w_idx_nx;
      r_pend_up <= w_pend_up_nx;
      r_pend_dn <= w_pend_dn_nx;
      r_dwell   <= w_dwell_nx;
      if (w_bnd) r_width <= BASE32 + 32'(w_idx_nx) * STEP32;
    end
  end

  assign st     = r_idx;
  assign st_chg = r_chg;
  assign pwm    = r_pwm;

endmodule
